uart_tx_fifo: RTL and testbench

- Synthesizable serial transmitter with a write FIFO. Drives the `uart_rx` pin of computer2 with framed bytes.
- Replaces hand-timed bit toggling of the receive line in benches and board-level loopback.
- Generalised over bit period, data width, stop-bit count and FIFO depth.
- Sits between a byte producer (bench sequencer or host-side logic) and the serial line.

---
 rtl/uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: serial transmitter fed by a write FIFO.
// Frames are start(0), DATA_BITS data bits LSB first, optional parity, and
// STOP_BITS stop bits(1), each held CLKS_PER_BIT clocks. Idle line is high.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
//
// Write handshake: wr_en acts as "valid" and ~full as "ready". A byte is
// accepted on a rising edge where wr_en=1 and the registered full=0. wr_en
// while full drops the byte and sets the sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [DATA_BITS-1:0]         wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         busy,
  output logic                         tx,
  output logic [2:0]                   dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  // Elaboration-time parameter legality checks.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, empty_q, overflow_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Transmitter state
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q, busy_q;
  logic                 bit_end, stop_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (cnt_q == CNT_MAX);
  assign stop_done = bit_end && (bit_q == STOP_LAST);
  assign push      = wr_en && !full_q;
  // The FSM takes the head entry when idle or on the final stop cycle.
  assign pop       = !empty_q &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_done));

  // Next occupancy: simultaneous push and pop leave the level unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // FIFO storage write; contents are invalidated by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LEVEL_FULL);
      empty_q <= (level_d == '0);
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^head) ^ PARITY_ODD[0];
`endif
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (pop) begin
                // Back-to-back frame: no idle gap.
                shift_q <= head;
`ifdef UART_TX_PARITY_EN
                par_q   <= (^head) ^ PARITY_ODD[0];
`endif
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          bit_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;
  assign tx          = tx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo. A default instance covers
// framing, latency, back-to-back, full/overflow and mid-frame reset; a second
// instance (CLKS_PER_BIT=3, DATA_BITS=7, STOP_BITS=2) covers the parameter sweep.
module tb_uart_tx_fifo;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, tx;
  logic [3:0] level;
  logic [2:0] dbg_state;

  // Sweep instance
  logic       wr_en2;
  logic [6:0] wr_data2;
  logic       full2, empty2, overflow2, busy2, tx2;
  logic [3:0] level2;
  logic [2:0] dbg_state2;

  uart_tx_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .busy(busy), .tx(tx), .dbg_state_o(dbg_state)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(7), .STOP_BITS(2), .DEPTH(8)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .level(level2), .overflow(overflow2),
    .busy(busy2), .tx(tx2), .dbg_state_o(dbg_state2)
  );

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS  = 11;
  localparam int FRAME2_BITS = 11;
`else
  localparam int FRAME_BITS  = 10;
  localparam int FRAME2_BITS = 10;
`endif
  localparam int CPB = 16;

  int n_checks = 0;
  int n_fail   = 0;

  // Table: byte, hand-written {data, start} bits (bit0 = start), even parity.
  typedef struct {
    logic [7:0] data;
    logic [8:0] head_bits;
    logic       par;
  } vec_t;
  vec_t vecs [8];

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic txv(input int which);
    return (which == 0) ? tx : tx2;
  endfunction

  function automatic logic busyv(input int which);
    return (which == 0) ? busy : busy2;
  endfunction

  // Expected line levels per bit for an 8-bit frame on the default instance.
  function automatic logic [15:0] model_bits(input logic [7:0] d);
    logic [15:0] e;
    e = '1;
    e[0] = 1'b0;
    for (int i = 0; i < 8; i++) e[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    e[9] = ^d;
`endif
    return e;
  endfunction

  function automatic logic [15:0] table_bits(input vec_t v);
    logic [15:0] e;
    e = '1;
    e[8:0] = v.head_bits;
`ifdef UART_TX_PARITY_EN
    e[9] = v.par;
`endif
    return e;
  endfunction

  // Scoreboard for one frame: waits (bounded) for the start bit, then checks
  // tx and busy on every cycle of every bit. skip = cycles of the start bit
  // already elapsed when called. Ends exactly at the edge after the frame.
  task automatic check_frame(input int which, input int cpb, input int nb,
                             input logic [15:0] eb, input int skip,
                             input string name, output int waited);
    int  w;
    logic bad;
    logic got;
    w = 0;
    while (txv(which) !== 1'b0 && w < 2000) begin
      tick();
      w++;
    end
    waited = w;
    if (w >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_start: got no start bit expected start within 2000 cycles", name);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      bad = 1'b0;
      got = eb[k];
      for (int c = ((k == 0) ? skip : 0); c < cpb; c++) begin
        if (txv(which) !== eb[k] || busyv(which) !== 1'b1) begin
          if (!bad) got = txv(which);
          bad = 1'b1;
        end
        tick();
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s_bit%0d: got tx=%0b (or busy low) expected tx=%0b busy=1",
                 name, k, got, eb[k]);
      end
    end
  endtask

  // Watchdog: hard stop if something blocks forever.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int seen;

    vecs[0] = '{8'h55, 9'b010101010, 1'b0};
    vecs[1] = '{8'hA5, 9'b101001010, 1'b0};
    vecs[2] = '{8'h0F, 9'b000011110, 1'b0};
    vecs[3] = '{8'hFF, 9'b111111110, 1'b0};
    vecs[4] = '{8'h00, 9'b000000000, 1'b0};
    vecs[5] = '{8'h07, 9'b000001110, 1'b1};
    vecs[6] = '{8'h80, 9'b100000000, 1'b1};
    vecs[7] = '{8'h3C, 9'b001111000, 1'b0};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_en2 = 1'b0; wr_data2 = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_full", full, 0);
    chk("rst_empty", empty, 1); chk("rst_level", level, 0); chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);

    // Table-driven single frames, including write-to-start latency
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = vecs[i].data;
      tick();                         // edge N: accepted
      wr_en = 1'b0; wr_data = ~vecs[i].data;
      chk($sformatf("v%0d_pre_tx", i), tx, 1);
      chk($sformatf("v%0d_lvl1", i), level, 1);
      tick();                         // edge N+1: start bit
      chk($sformatf("v%0d_tx_low", i), tx, 0);
      chk($sformatf("v%0d_lvl0", i), level, 0);
      check_frame(0, CPB, FRAME_BITS, table_bits(vecs[i]), 0, $sformatf("v%0d", i), waited);
      chk($sformatf("v%0d_waited", i), waited, 0);
      chk($sformatf("v%0d_end_busy", i), busy, 0);
      chk($sformatf("v%0d_end_tx", i), tx, 1);
      repeat (3) tick();
    end

    // Back-to-back frames
    wr_en = 1'b1; wr_data = 8'hA5; tick();
    chk("b2b_lvl_a", level, 1);
    wr_data = 8'h0F; tick();          // first frame starts here
    chk("b2b_lvl_b", level, 1);
    wr_data = 8'hFF; tick();
    chk("b2b_lvl_c", level, 2);
    wr_en = 1'b0;
    check_frame(0, CPB, FRAME_BITS, model_bits(8'hA5), 1, "b2b0", waited);
    chk("b2b0_waited", waited, 0);
    chk("b2b_lvl_d", level, 1);
    check_frame(0, CPB, FRAME_BITS, model_bits(8'h0F), 0, "b2b1", waited);
    chk("b2b1_gap", waited, 0);
    chk("b2b_lvl_e", level, 0);
    check_frame(0, CPB, FRAME_BITS, model_bits(8'hFF), 0, "b2b2", waited);
    chk("b2b2_gap", waited, 0);
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_empty", empty, 1);
    repeat (3) tick();

    // Full / overflow: 10 writes on consecutive cycles
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
      if (i == 0) chk("ovf_w0_ovf", overflow, 0);
      if (i == 7) begin chk("ovf_w7_full", full, 0); chk("ovf_w7_lvl", level, 7); end
      if (i == 8) begin chk("ovf_w8_full", full, 1); chk("ovf_w8_lvl", level, 8); end
      if (i == 9) begin chk("ovf_w9_ovf", overflow, 1); chk("ovf_w9_lvl", level, 8); end
    end
    wr_en = 1'b0;
    for (int f = 0; f < 9; f++) begin
      check_frame(0, CPB, FRAME_BITS, model_bits(8'h10 + 8'(f)), (f == 0) ? 8 : 0,
                  $sformatf("ovf_f%0d", f), waited);
      chk($sformatf("ovf_f%0d_gap", f), waited, 0);
    end
    chk("ovf_end_busy", busy, 0);
    chk("ovf_sticky", overflow, 1);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (tx !== 1'b1) seen++;
      tick();
    end
    chk("ovf_no_tenth", seen, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("ovf_clr", overflow, 0);
    tick();

    // Reset mid-frame during data bit 3 of 0x00, with a second byte queued
    wr_en = 1'b1; wr_data = 8'h00; tick();
    wr_data = 8'h33; tick();          // start bit begins
    wr_en = 1'b0;
    repeat (72) tick();               // middle of data bit 3
    chk("mid_tx_low", tx, 0);
    chk("mid_lvl", level, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_tx", tx, 1); chk("mid_busy", busy, 0); chk("mid_level", level, 0);
    chk("mid_ovf", overflow, 0); chk("mid_empty", empty, 1);
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0) seen++;
      tick();
    end
    chk("mid_no_frames", seen, 0);

    // Parameter sweep instance: 0x41, 7 data bits, 2 stop bits, 3 clocks/bit
    wr_en2 = 1'b1; wr_data2 = 7'h41; tick();
    wr_en2 = 1'b0; wr_data2 = 7'h00;
    chk("sw_pre_tx", tx2, 1);
    tick();
    chk("sw_tx_low", tx2, 0);
`ifdef UART_TX_PARITY_EN
    check_frame(1, 3, FRAME2_BITS, 16'b1111_1110_1000_0010, 0, "sw", waited);
`else
    check_frame(1, 3, FRAME2_BITS, 16'b1111_1111_1000_0010, 0, "sw", waited);
`endif
    chk("sw_waited", waited, 0);
    chk("sw_end_busy", busy2, 0);
    chk("sw_end_tx", tx2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
